// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared constants and helpers for the seven-segment scan
//                multiplexer and its hex_to_sseg companions. All display
//                drive is active low (common-anode display).
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam int         NUM_DIGITS = 4;

    // Active-low drive levels shared with hex_to_sseg users
    localparam logic       ANODE_ON   = 1'b0;
    localparam logic       SEG_ON     = 1'b0;
    localparam logic       SEG_OFF    = 1'b1;

    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam logic       DP_OFF     = 1'b1;

    // Active-low one-cold anode pattern for the selected digit
    function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Nibble idx of a 16-bit hex value (digit 0 is the rightmost)
    function automatic logic [3:0] nibble_at(input logic [15:0] v,
                                             input logic [1:0]  idx);
        return v[idx*4 +: 4];
    endfunction

    // True when digit idx and every more-significant digit is zero; digit 0
    // is never treated as a leading zero so a zero value still shows "0"
    function automatic logic leading_zero(input logic [15:0] v,
                                          input logic [1:0]  idx);
        return (idx != 2'd0) && ((v >> {idx, 2'b00}) == 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_refresh_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_refresh_prescaler
//  Description : Free-running digit-slot counter 0..REFRESH_DIV-1 with a
//                single-cycle tick on the last count of each slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_refresh_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(REFRESH_DIV - 1);

    // Tick marks the final cycle of a slot; the count wraps on it
    assign tick = (cnt == C_LAST);

    // Slot counter, restarts at zero after the last count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_mux
//  Description : Time-multiplexed driver for a 4-digit common-anode display.
//                Scans one nibble per slot, blanks the anodes during a guard
//                interval at the start of each slot and optionally blanks
//                leading zero digits. Outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] w_cnt;
    logic             w_tick;
    logic [1:0]       r_idx;
    logic [15:0]      r_sh_val;
    logic [3:0]       r_sh_dp;
    logic             r_sh_lz;
    logic             w_guard;
    logic             w_lead;
    logic             w_blank;

    sseg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .cnt   (w_cnt),
        .tick  (w_tick)
    );

    // Advance the selected digit at the end of every slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Capture display data; independent of the scan position so a load on a
    // slot boundary is seen by the very next slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_val <= 16'h0000;
            r_sh_dp  <= 4'b0000;
            r_sh_lz  <= 1'b0;
        end else if (load) begin
            r_sh_val <= value;
            r_sh_dp  <= dp_in;
            r_sh_lz  <= blank_lz;
        end
    end

    // Guard window at the head of each slot; with no guard the compare
    // would be against zero and is dropped entirely
    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] C_GUARD = CNT_W'(GUARD);
            assign w_guard = (w_cnt < C_GUARD);
        end
    endgenerate

    assign w_lead  = r_sh_lz && leading_zero(r_sh_val, r_idx);
    assign w_blank = w_guard || w_lead;

    // Registered display drive; digit always tracks the selected nibble so it
    // is deterministic even while the anodes are off
    always_ff @(posedge clk) begin
        if (reset) begin
            an    <= ANODE_OFF;
            digit <= 4'h0;
            dp    <= DP_OFF;
        end else begin
            digit <= nibble_at(r_sh_val, r_idx);
            if (w_blank) begin
                an <= ANODE_OFF;
                dp <= DP_OFF;
            end else begin
                an <= anode_sel_n(r_idx);
                dp <= ~r_sh_dp[r_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sseg_scan_mux
//  Description : Self-checking bench for sseg_scan_mux with REFRESH_DIV=4,
//                GUARD=1. A time-based reference model predicts every output
//                cycle; table rows and short sequences add targeted checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_mux;

    localparam int RD = 4;
    localparam int GD = 1;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        load     = 1'b0;
    logic [15:0] value    = 16'h0;
    logic [3:0]  dp_in    = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset and the loaded display data
    int          m_pos   = 0;
    logic [15:0] m_val   = 16'h0;
    logic [3:0]  m_dpv   = 4'h0;
    logic        m_lz    = 1'b0;
    logic        m_valid = 1'b0;
    logic [3:0]  e_an    = 4'hF;
    logic [3:0]  e_dig   = 4'h0;
    logic        e_dp    = 1'b1;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic            lz;
        logic [3:0][3:0] an_s;
        logic [3:0][3:0] dig_s;
        logic [3:0]      dpo_s;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .digit    (digit),
        .an       (an),
        .dp       (dp)
    );

    // What the display should show for the state reached pos cycles after reset
    task automatic model_out(input int pos, input logic [15:0] v,
                             input logic [3:0] dpv, input logic lz,
                             output logic [3:0] o_an, output logic [3:0] o_dig,
                             output logic o_dp);
        int   slot;
        int   phase;
        int   upper;
        logic blank;
        slot  = (pos / RD) % 4;
        phase = pos % RD;
        upper = int'(v) / (1 << (4 * slot));
        o_dig = 4'((int'(v) / (1 << (4 * slot))) % 16);
        blank = (phase < GD) || (lz && slot != 0 && upper == 0);
        o_an  = blank ? 4'hF : 4'(15 - (1 << slot));
        o_dp  = blank ? 1'b1 : ~dpv[slot];
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare
    task automatic cyc();
        if (reset) begin
            e_an = 4'hF; e_dig = 4'h0; e_dp = 1'b1;
            m_pos = 0; m_val = 16'h0; m_dpv = 4'h0; m_lz = 1'b0;
            m_valid = 1'b1;
        end else begin
            model_out(m_pos, m_val, m_dpv, m_lz, e_an, e_dig, e_dp);
            m_pos++;
            if (load) begin
                m_val = value; m_dpv = dp_in; m_lz = blank_lz;
            end
        end
        @(posedge clk);
        #1;
        if (m_valid) begin
            vectors++;
            if (an !== e_an || digit !== e_dig || dp !== e_dp) begin
                miscompares++;
                $display("FAIL model pos=%0d: an=%b digit=%h dp=%b, expected an=%b digit=%h dp=%b",
                         m_pos, an, digit, dp, e_an, e_dig, e_dp);
            end
            chk("an_one_cold", ($countones(~an) <= 1) ? 1 : 0, 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'hA3C5, 4'b0100, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {4'hA, 4'h3, 4'hC, 4'h5}, 4'b1011};
        tbl[1] = '{16'h0042, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                   {4'h0, 4'h0, 4'h4, 4'h2}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                   {4'h0, 4'h0, 4'h0, 4'h0}, 4'b1111};
        tbl[3] = '{16'h0100, 4'b0011, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                   {4'h0, 4'h1, 4'h0, 4'h0}, 4'b1100};
        tbl[4] = '{16'h1234, 4'b1111, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {4'h1, 4'h2, 4'h3, 4'h4}, 4'b0000};
        tbl[5] = '{16'hF00F, 4'b1001, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {4'hF, 4'h0, 4'h0, 4'hF}, 4'b0110};

        // Reset held three cycles, then the guard cycle, then digit 0
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_an", an, 4'hF);
            chk("rst_dp", dp, 1);
            chk("rst_digit", digit, 0);
        end
        reset = 1'b0;
        cyc();
        chk("post_rst_an", an, 4'hF);
        cyc();
        chk("first_enable_an", an, 4'b1110);
        for (int i = 0; i < 16; i++) cyc();

        // Table rows: load right at reset release, then watch four slots
        for (int r = 0; r < 6; r++) begin
            do_reset();
            load = 1'b1; value = tbl[r].val; dp_in = tbl[r].dpi; blank_lz = tbl[r].lz;
            cyc();
            load = 1'b0;
            for (int k = 2; k <= 17; k++) begin
                int p;
                int slot;
                cyc();
                p    = k - 1;
                slot = (p / RD) % 4;
                if (p % RD < GD) begin
                    chk($sformatf("row%0d_guard_an", r), an, 4'hF);
                    chk($sformatf("row%0d_guard_dp", r), dp, 1);
                end else begin
                    chk($sformatf("row%0d_slot%0d_an", r, slot), an, tbl[r].an_s[slot]);
                    chk($sformatf("row%0d_slot%0d_dp", r, slot), dp, tbl[r].dpo_s[slot]);
                end
                chk($sformatf("row%0d_slot%0d_digit", r, slot), digit, tbl[r].dig_s[slot]);
            end
        end

        // Load coincident with the slot 1 -> 2 change
        do_reset();
        load = 1'b1; value = 16'hABCD; dp_in = 4'h0; blank_lz = 1'b0;
        cyc();
        load = 1'b0;
        for (int k = 2; k <= 7; k++) cyc();
        load = 1'b1; value = 16'h1234;
        cyc();
        load = 1'b0;
        cyc();
        chk("bnd_guard_an", an, 4'hF);
        chk("bnd_guard_digit", digit, 2);
        for (int k = 10; k <= 12; k++) begin
            cyc();
            chk("bnd_slot2_an", an, 4'b1011);
            chk("bnd_slot2_digit", digit, 2);
        end

        // Reset in the middle of slot 2
        do_reset();
        load = 1'b1; value = 16'h5555; dp_in = 4'hF; blank_lz = 1'b0;
        cyc();
        load = 1'b0;
        for (int k = 2; k <= 10; k++) cyc();
        chk("mid_pre_an", an, 4'b1011);
        reset = 1'b1;
        cyc();
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_dp", dp, 1);
        chk("mid_rst_digit", digit, 0);
        reset = 1'b0;
        cyc();
        cyc();
        chk("mid_after_an", an, 4'b1110);
        chk("mid_after_digit", digit, 0);
        chk("mid_after_dp", dp, 1);

        // Random loads and occasional resets against the model
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            reset    = ($urandom_range(0, 499) == 0);
            load     = ($urandom_range(0, 7) == 0);
            value    = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            cyc();
        end
        reset = 1'b0; load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
